song_reader: RTL and testbench



---
 rtl/song_pkg.sv | 34 +++
 rtl/song_reader.sv | 129 ++++++++++++
 tb/tb_song_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song ROM format and the song reader FSM.
// Used by the reader, the note player and the ROM generator.
package song_pkg;

  localparam int SONG_W   = 2;
  localparam int IDX_W    = 5;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int ENTRY_W  = 16;
  localparam int NOTE_LSB = 9;
  localparam int DUR_LSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } reader_state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } song_entry_t;

  // Bit 15 and bits [2:0] of a ROM word are reserved and dropped here.
  function automatic song_entry_t decode_entry(input logic [ENTRY_W-1:0] word);
    song_entry_t e;
    e.note = word[NOTE_LSB +: NOTE_W];
    e.dur  = word[DUR_LSB +: DUR_W];
    return e;
  endfunction

endpackage

// File: rtl/song_reader.sv
// Walks one song in the registered song ROM and hands note/duration pairs
// to the note player, advancing only after the player's completion pulse.
module song_reader
  import song_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]      rom_data,
  input  logic                    note_done,
  output logic                    new_note,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    song_done,
  output reader_state_t           dbg_state
);

  // Handshake: new_note is a one-cycle strobe; note/duration become valid with
  // it and hold until the next strobe. The player answers with a one-cycle
  // note_done, which is ignored in the strobe cycle itself.

  reader_state_t     r_state;
  reader_state_t     w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [SONG_W-1:0] r_song_q;
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_dur;
  logic              r_new_note;
  logic              r_song_done;

  song_entry_t w_entry;
  logic        w_song_change;
  logic        w_load_song;
  logic        w_idx_clr;
  logic        w_idx_inc;
  logic        w_issue;
  logic        w_end;

  assign w_entry       = decode_entry(rom_data);
  assign w_song_change = (r_state != ST_IDLE) && (song != r_song_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load_song  = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_issue      = 1'b0;
    w_end        = 1'b0;
    // A song change abandons the current song silently, whatever the state.
    if (w_song_change) begin
      w_next_state = ST_IDLE;
      w_idx_clr    = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_load_song = 1'b1;
          w_idx_clr   = 1'b1;
          if (play) w_next_state = ST_FETCH;
        end
        ST_FETCH: begin
          if (play) w_next_state = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_entry.dur == '0) begin
            w_next_state = ST_DONE;
            w_end        = 1'b1;
          end else if (play) begin
            w_next_state = ST_WAIT_DONE;
            w_issue      = 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (note_done && !r_new_note) begin
            if (r_idx != {IDX_W{1'b1}}) begin
              w_idx_inc    = 1'b1;
              w_next_state = ST_FETCH;
            end else begin
              w_next_state = ST_DONE;
              w_end        = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!play) begin
            w_next_state = ST_IDLE;
            w_idx_clr    = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_song_q    <= '0;
      r_note      <= '0;
      r_dur       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_load_song) r_song_q <= song;
      if (w_issue) begin
        r_note <= w_entry.note;
        r_dur  <= w_entry.dur;
      end
      r_new_note  <= w_issue;
      r_song_done <= w_end;
    end
  end

  assign rom_addr  = {r_song_q, r_idx};
  assign new_note  = r_new_note;
  assign note      = r_note;
  assign duration  = r_dur;
  assign song_done = r_song_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: a ROM model, a randomized note player,
// and a scoreboard fed from a song-walking reference model.
module tb_song_reader;
  import song_pkg::*;

  localparam int AW = SONG_W + IDX_W;
  localparam int W  = 1 + AW + NOTE_W + DUR_W;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                play = 1'b0;
  logic [SONG_W-1:0]   song = '0;
  logic [AW-1:0]       rom_addr;
  logic [15:0]         rom_data;
  logic                note_done = 1'b0;
  logic                new_note;
  logic [NOTE_W-1:0]   note;
  logic [DUR_W-1:0]    duration;
  logic                song_done;
  reader_state_t       dbg_state;

  logic [15:0]         rom_mem [0:(1<<AW)-1];
  logic [W-1:0]        exp_q [$];
  int                  n_checks = 0;
  int                  n_fail = 0;
  bit                  player_en = 1'b0;
  logic [NOTE_W-1:0]   last_note = '0;
  logic [DUR_W-1:0]    last_dur = '0;

  song_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .song      (song),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_done (note_done),
    .new_note  (new_note),
    .note      (note),
    .duration  (duration),
    .song_done (song_done),
    .dbg_state (dbg_state)
  );

  // clock / registered ROM
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic k, input logic [AW-1:0] a,
                                       input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
    return {k, a, n, d};
  endfunction

  // term = index of the terminator entry; 32 means a full song of notes
  task automatic fill_song(input int s, input int term);
    logic [15:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      if (i == term)         w[8:3] = 6'd0;
      else if (w[8:3] == 0)  w[8:3] = 6'd1;
      rom_mem[AW'(s*32 + i)] = w;
    end
  endtask

  // Reference model: the song plays entries in order until a zero duration
  // or the 32nd entry, then ends where it stopped.
  task automatic push_model(input int s);
    logic [15:0]   w;
    logic [AW-1:0] a;
    for (int i = 0; i < 32; i++) begin
      a = AW'(s*32 + i);
      w = rom_mem[a];
      if (w[8:3] == 6'd0) begin
        exp_q.push_back(mk(1'b1, a, '0, '0));
        return;
      end
      exp_q.push_back(mk(1'b0, a, w[14:9], w[8:3]));
    end
    exp_q.push_back(mk(1'b1, AW'(s*32 + 31), '0, '0));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!reset_n) begin
      last_note = '0;
      last_dur  = '0;
    end else if (new_note || song_done) begin
      check("strobe_exclusive", 32'(new_note && song_done), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(rom_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(song_done), 32'(e[W-1]));
        check("event_addr", 32'(rom_addr), 32'(e[W-2 -: AW]));
        if (!e[W-1]) begin
          check("event_note", 32'(note), 32'(e[NOTE_W+DUR_W-1 -: NOTE_W]));
          check("event_dur", 32'(duration), 32'(e[DUR_W-1:0]));
          last_note = e[NOTE_W+DUR_W-1 -: NOTE_W];
          last_dur  = e[DUR_W-1:0];
        end else begin
          check("done_note_held", 32'(note), 32'(last_note));
          check("done_dur_held", 32'(duration), 32'(last_dur));
        end
      end
    end
  end

  // note player
  initial begin
    forever begin
      @(posedge clk); #1;
      if (player_en && reset_n && new_note) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 note_done = 1'b1;
        @(posedge clk);
        #1 note_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input reader_state_t st, input int max, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(posedge clk); #1;
      got = (dbg_state == st);
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic hold_low(input string tag, input reader_state_t st);
    logic [AW-1:0] a = rom_addr;
    int strobes = 0;
    int moved = 0;
    play = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (new_note) strobes++;
      if (rom_addr != a || dbg_state != st) moved++;
    end
    check({tag, "_strobes"}, 32'(strobes), 32'd0);
    check({tag, "_moved"}, 32'(moved), 32'd0);
    play = 1'b1;
  endtask

  task automatic finish_song(input int hold);
    bit got = 1'b0;
    bit stable = 1'b1;
    logic [AW-1:0] a;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      got = song_done;
    end
    check("song_done_seen", 32'(got), 32'd1);
    check("done_state", 32'(dbg_state), 32'(ST_DONE));
    a = rom_addr;
    repeat (hold) begin
      @(posedge clk); #1;
      if (rom_addr != a || dbg_state != ST_DONE || song_done || new_note) stable = 1'b0;
    end
    if (hold > 0) check("done_hold_stable", 32'(stable), 32'd1);
    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    play = 1'b0;
    @(posedge clk); #1;
    check("back_to_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_idx_zero", 32'(rom_addr[IDX_W-1:0]), 32'd0);
    check("idle_note_held", 32'(note), 32'(last_note));
    check("idle_dur_held", 32'(duration), 32'(last_dur));
  endtask

  initial begin
    int s, t;
    bit got;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_dur", 32'(duration), 32'd0);
    check("rst_new_note", 32'(new_note), 32'd0);
    check("rst_song_done", 32'(song_done), 32'd0);
    reset_n = 1'b1;

    // first note latency and note_done advance, song 1
    fill_song(1, 2);
    rom_mem[32] = {1'b0, 6'd35, 6'd36, 3'b101};
    push_model(1);
    @(posedge clk); #1;
    song = 2'd1;
    play = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("fetch_addr", 32'(rom_addr), 32'd32);
      check($sformatf("play_latency_c%0d", c), 32'(new_note), 32'(c == 3));
    end
    check("first_note", 32'(note), 32'd35);
    check("first_dur", 32'(duration), 32'd36);
    @(posedge clk); #1;
    note_done = 1'b1;
    @(posedge clk); #1;
    note_done = 1'b0;
    check("advance_addr", 32'(rom_addr), 32'd33);
    check("advance_state", 32'(dbg_state), 32'(ST_FETCH));
    @(posedge clk); #1;
    check("done_latency_b", 32'(new_note), 32'd0);
    @(posedge clk); #1;
    check("done_latency_c", 32'(new_note), 32'd1);
    check("second_addr", 32'(rom_addr), 32'd33);
    @(posedge clk); #1;
    note_done = 1'b1;
    @(posedge clk); #1;
    note_done = 1'b0;
    finish_song(0);
    check("idle_addr_song1", 32'(rom_addr), 32'd32);

    // terminator at idx 5, song 2
    player_en = 1'b1;
    fill_song(2, 5);
    push_model(2);
    song = 2'd2;
    play = 1'b1;
    finish_song(0);

    // full 32-note song, song 3: must stop at idx 31
    fill_song(3, 32);
    push_model(3);
    song = 2'd3;
    play = 1'b1;
    finish_song(6);

    // play low in FETCH and ISSUE
    fill_song(0, 6);
    push_model(0);
    song = 2'd0;
    play = 1'b1;
    wait_state(ST_FETCH, 5, "reach_fetch");
    hold_low("fetch_hold", ST_FETCH);
    @(posedge clk); #1;
    check("reach_issue", 32'(dbg_state), 32'(ST_ISSUE));
    hold_low("issue_hold", ST_ISSUE);
    @(posedge clk); #1;
    check("issue_release_strobe", 32'(new_note), 32'd1);
    finish_song(0);

    // song change 2 -> 3 while waiting for note_done
    player_en = 1'b0;
    fill_song(2, 32);
    push_model(2);
    song = 2'd2;
    play = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = new_note;
    end
    check("chg_first_strobe", 32'(got), 32'd1);
    @(posedge clk); #1;
    check("chg_in_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
    song = 2'd3;
    play = 1'b0;
    @(posedge clk); #1;
    check("chg_state", 32'(dbg_state), 32'(ST_IDLE));
    check("chg_idx", 32'(rom_addr[IDX_W-1:0]), 32'd0);
    check("chg_no_song_done", 32'(song_done), 32'd0);
    check("chg_note_held", 32'(note), 32'(rom_mem[64][14:9]));
    exp_q.delete();
    @(posedge clk); #1;
    check("chg_new_song_addr", 32'(rom_addr), 32'd96);

    // asynchronous reset in ISSUE
    fill_song(1, 32);
    push_model(1);
    song = 2'd1;
    play = 1'b1;
    wait_state(ST_ISSUE, 10, "rst_reach_issue");
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_note", 32'(note), 32'd0);
    check("mid_rst_dur", 32'(duration), 32'd0);
    check("mid_rst_new_note", 32'(new_note), 32'd0);
    check("mid_rst_song_done", 32'(song_done), 32'd0);
    play = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_new_note", 32'(new_note), 32'd0);

    // randomized songs
    player_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s = $urandom_range(0, 3);
      t = $urandom_range(0, 32);
      fill_song(s, t);
      push_model(s);
      song = SONG_W'(s);
      @(posedge clk); #1;
      play = 1'b1;
      finish_song($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
